button_encoder: RTL

//  Front end for the four colour buttons; sits directly upstream of the game controller.
//  - Synchronises and debounces four raw, asynchronous, active-high buttons.
//  - Encodes a single clean press into a 2-bit colour code with a one-cycle valid strobe.
//  - Rejects chords (two or more buttons down together).
//  - Provides a press strobe that is independent of ENABLE, for game start.

---
 rtl/button_encoder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/button_encoder.sv
// Colour-button front end: sync, debounce, single-press encode.
// Chords lock out until full release; ANY_PRESS ignores ENABLE.
module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] BTN,
  input  logic       ENABLE,
  output logic [1:0] IN,
  output logic       IN_VALID,
  output logic       HELD,
  output logic       ANY_PRESS
);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    LOCKOUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       sync1_q;
  logic [3:0]       sync_q;
  logic [3:0]       deb_q, deb_d;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  state_t           state_q, state_d;
  logic [1:0]       in_q, in_d;
  logic             in_valid_q, in_valid_d;
  logic             held_q, held_d;
  logic             any_press_q, any_press_d;
  logic [2:0]       n;
  logic [1:0]       idx;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cnt_d[k] = cnt_q[k];
      deb_d[k] = deb_q[k];
      if (sync_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_MAX) begin
        deb_d[k] = sync_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  assign n = {2'b0, deb_q[0]} + {2'b0, deb_q[1]}
           + {2'b0, deb_q[2]} + {2'b0, deb_q[3]};

  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    in_valid_d  = 1'b0;
    held_d      = held_q;
    idx         = 2'd0;
    any_press_d = (|deb_q) & ~(|prev_q);
    unique case (state_q)
      IDLE: begin
        if (n == 3'd1 && ENABLE) begin
          // idx decode only runs with exactly one bit set
          unique case (1'b1)
            deb_q[0]: idx = 2'd0;
            deb_q[1]: idx = 2'd1;
            deb_q[2]: idx = 2'd2;
            deb_q[3]: idx = 2'd3;
            default:  idx = 2'd0;
          endcase
          in_d       = idx;
          in_valid_d = 1'b1;
          held_d     = 1'b1;
          state_d    = PRESSED;
        end else if (n != 3'd0) begin
          state_d = LOCKOUT;
        end
      end
      PRESSED: begin
        held_d = 1'b1;
        if (n == 3'd0) begin
          held_d  = 1'b0;
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (n == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      deb_q       <= '0;
      prev_q      <= '0;
      for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      state_q     <= IDLE;
      in_q        <= '0;
      in_valid_q  <= 1'b0;
      held_q      <= 1'b0;
      any_press_q <= 1'b0;
    end else begin
      sync1_q     <= BTN;
      sync_q      <= sync1_q;
      deb_q       <= deb_d;
      prev_q      <= deb_q;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
      state_q     <= state_d;
      in_q        <= in_d;
      in_valid_q  <= in_valid_d;
      held_q      <= held_d;
      any_press_q <= any_press_d;
    end
  end

  assign IN        = in_q;
  assign IN_VALID  = in_valid_q;
  assign HELD      = held_q;
  assign ANY_PRESS = any_press_q;

endmodule
